distribute_1x2_cmd_scheduler: RTL

Programmable command sequencer that drives one distribute_1x2_simple_seq switch (i_valid, i_en, i_cmd). It holds a small table of {cmd, repeat} entries and plays them out beat by beat against an upstream valid/ready stream. Upstream data goes straight to the switch data bus; this block supplies only control.
It also inserts the bubble commands the switch needs, because the switch holds its outputs and o_valid whenever i_valid or i_en is low. It sits between the producer and the switch in AcceleratorNoC distribution trees.

---
 rtl/dist_sched_pkg.sv | 17 +
 rtl/dist_cmd_table.sv | 41 ++++
 rtl/distribute_1x2_cmd_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dist_sched_pkg.sv
// Shared definitions for the distribute_1x2 command scheduler.
//   CMD_*  : switch command encodings (NA / low / high / dup)
//   state_t: scheduler FSM states
package dist_sched_pkg;

  localparam logic [1:0] CMD_NA   = 2'b00;
  localparam logic [1:0] CMD_LOW  = 2'b01;
  localparam logic [1:0] CMD_HIGH = 2'b10;
  localparam logic [1:0] CMD_DUP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/dist_cmd_table.sv
// Command table: DEPTH entries of {cmd, repeat}.
//   clk, rst          : clock, synchronous active-high clear of every entry
//   wr_en/wr_addr/... : synchronous write port
//   rd_addr           : combinational read index
//   rd_cmd/rd_repeat  : entry at rd_addr
module dist_cmd_table #(
  parameter int CMD_WIDTH    = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [CMD_WIDTH-1:0]    wr_cmd,
  input  logic [REPEAT_WIDTH-1:0] wr_repeat,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [CMD_WIDTH-1:0]    rd_cmd,
  output logic [REPEAT_WIDTH-1:0] rd_repeat
);

  logic [DEPTH-1:0][CMD_WIDTH-1:0]    cmd_mem;
  logic [DEPTH-1:0][REPEAT_WIDTH-1:0] rep_mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        cmd_mem[i] <= '0;
        rep_mem[i] <= '0;
      end else if (wr_en && wr_addr == ADDR_WIDTH'(i)) begin
        cmd_mem[i] <= wr_cmd;
        rep_mem[i] <= wr_repeat;
      end
    end
  end

  assign rd_cmd    = cmd_mem[rd_addr];
  assign rd_repeat = rep_mem[rd_addr];

endmodule

// File: rtl/distribute_1x2_cmd_scheduler.sv
// Programmable command sequencer for a distribute_1x2_simple_seq switch.
// Plays a table of {cmd, repeat} entries against an upstream valid/ready
// stream and inserts CMD_NA bubbles so the switch output never holds stale
// valids. Data goes straight from the producer to the switch; this block only
// supplies control.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cfg_wr_*            : table write port (IDLE only)
//   cfg_num_entries     : entries to play, 1..DEPTH, sampled at start
//   start / stop        : begin playback (IDLE) / abort (RUN)
//   loop_en             : wrap to entry 0 instead of finishing, sampled at start
//   in_valid, in_ready  : upstream handshake
//   sw_valid/sw_en/sw_cmd : switch control (i_valid, i_en, i_cmd)
//   busy                : RUN or FLUSH
//   done                : one-cycle pulse during the FLUSH cycle
// Optional: define DIST_SCHED_BEAT_CNT_EN to add a saturating 32-bit beat_cnt
// output counting accepted beats since the last start.
module distribute_1x2_cmd_scheduler
  import dist_sched_pkg::*;
#(
  parameter int CMD_WIDTH    = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]   cfg_wr_addr,
  input  logic [CMD_WIDTH-1:0]    cfg_wr_cmd,
  input  logic [REPEAT_WIDTH-1:0] cfg_wr_repeat,
  input  logic [ADDR_WIDTH:0]     cfg_num_entries,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sw_valid,
  output logic                    sw_en,
  output logic [CMD_WIDTH-1:0]    sw_cmd,
  output logic                    busy,
  output logic                    done
`ifdef DIST_SCHED_BEAT_CNT_EN
  ,
  output logic [31:0]             beat_cnt
`endif
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [REPEAT_WIDTH-1:0] rep_cnt;
  logic [ADDR_WIDTH:0]     num;
  logic                    loop;
  logic [CMD_WIDTH-1:0]    ent_cmd;
  logic [REPEAT_WIDTH-1:0] ent_rep;
  logic                    hs;
  logic                    last;
  logic                    start_ok;

  dist_cmd_table #(
    .CMD_WIDTH   (CMD_WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REPEAT_WIDTH(REPEAT_WIDTH)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_wr_en && state == ST_IDLE),
    .wr_addr  (cfg_wr_addr),
    .wr_cmd   (cfg_wr_cmd),
    .wr_repeat(cfg_wr_repeat),
    .rd_addr  (ptr),
    .rd_cmd   (ent_cmd),
    .rd_repeat(ent_rep)
  );

  assign start_ok = cfg_num_entries != '0 &&
                    cfg_num_entries <= (ADDR_WIDTH+1)'(DEPTH);
  assign last     = {1'b0, ptr} == num - (ADDR_WIDTH+1)'(1);

  // Control is combinational so the command lines up with the beat the
  // switch captures in the same cycle. While rst is high sw_en stays on so
  // the switch's own synchronous reset is actually clocked in.
  always_comb begin
    in_ready = 1'b0;
    sw_en    = 1'b0;
    sw_valid = 1'b0;
    sw_cmd   = CMD_NA;
    busy     = 1'b0;
    if (rst) begin
      sw_en = 1'b1;
    end else if (state != ST_IDLE) begin
      sw_en    = 1'b1;
      sw_valid = 1'b1;   // bubble unless a beat is accepted below
      busy     = 1'b1;
      if (state == ST_RUN) begin
        in_ready = ~stop;
        if (in_valid && !stop) sw_cmd = ent_cmd;
      end
    end
  end

  assign hs = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      rep_cnt <= '0;
      num     <= '0;
      loop    <= 1'b0;
      done    <= 1'b0;
`ifdef DIST_SCHED_BEAT_CNT_EN
      beat_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && start_ok) begin
            num     <= cfg_num_entries;
            loop    <= loop_en;
            ptr     <= '0;
            rep_cnt <= '0;
            state   <= ST_RUN;
`ifdef DIST_SCHED_BEAT_CNT_EN
            beat_cnt <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_FLUSH;
            done  <= 1'b1;    // done is high for exactly the FLUSH cycle
          end else if (hs) begin
`ifdef DIST_SCHED_BEAT_CNT_EN
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 32'd1;
`endif
            // Compare before incrementing so an all-ones repeat gives
            // 2**REPEAT_WIDTH beats without wrapping rep_cnt.
            if (rep_cnt == ent_rep) begin
              rep_cnt <= '0;
              if (last) begin
                ptr <= '0;
                if (!loop) begin
                  state <= ST_FLUSH;
                  done  <= 1'b1;
                end
              end else begin
                ptr <= ptr + ADDR_WIDTH'(1);
              end
            end else begin
              rep_cnt <= rep_cnt + REPEAT_WIDTH'(1);
            end
          end
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
